uart_tx_generic: RTL and testbench
==================================

UART_TX_GENERIC -- requirements
Module: uart_tx_generic

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter PARITY_MODE, default 1: parity selection; 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 8: FIFO entries; power of 2, range 2..64.
REQ-005 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 baud_select  input  3  bit-period select.
REQ-008 Tx_EN  input  1  transmit enable.
REQ-009 Tx_WR  input  1  single-cycle write strobe.
REQ-010 Tx_DATA  input  DATA_W  data word to enqueue.
REQ-011 TxD  output  1  serial line; idle level is 1.
REQ-012 Tx_BUSY  output  1  frame in progress.
REQ-013 Tx_FULL  output  1  no free entry; registered.
REQ-014 Tx_EMPTY  output  1  no queued word; registered.
REQ-015 Tx_OVF  output  1  sticky flag: a write was dropped.

Function
REQ-016 BIT_CYCLES SHALL be selected by baud_select 0..7 as 5208, 1302, 326, 163, 81, 41, 27, 14 clk cycles.
REQ-017 baud_select SHALL be sampled only at frame start, so a change mid-frame has no effect on the current frame.
REQ-018 A Tx_WR sampled high while Tx_FULL=0 SHALL enqueue Tx_DATA.
REQ-019 A Tx_WR sampled high while Tx_FULL=1 SHALL be dropped and SHALL set Tx_OVF; this applies even if a pop occurs in the same cycle.
REQ-020 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_MODE=0.
REQ-021 IDLE -> START SHALL occur when Tx_EMPTY=0 and Tx_EN=1; the transition pops the head word into a shift register and latches BIT_CYCLES.
REQ-022 If Tx_WR is sampled at edge N with IDLE, empty FIFO and Tx_EN=1, TxD SHALL go 0 at edge N+2.
REQ-023 Each bit SHALL last exactly BIT_CYCLES clocks.
REQ-024 Bit order: start bit = 0, then data LSB first, then parity (even: XOR of data; odd: its inverse), then STOP_BITS bits of 1.
REQ-025 Frame length SHALL be (1 + DATA_W + (PARITY_MODE != 0) + STOP_BITS) * BIT_CYCLES clocks.
REQ-026 After the last stop bit, if Tx_EN=1 and Tx_EMPTY=0, START SHALL begin on the next clock with no idle gap; otherwise the FSM SHALL return to IDLE.
REQ-027 Tx_EN=0 SHALL NOT abort a frame in progress; it only blocks the next IDLE -> START.
REQ-028 Tx_BUSY SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-029 Tx_FULL and Tx_EMPTY SHALL reflect occupancy one clock after the enqueue or pop.
REQ-030 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 A simultaneous enqueue and pop on a non-full FIFO SHALL leave occupancy unchanged.

Reset
REQ-032 While reset=0, outputs SHALL be: TxD=1, Tx_BUSY=0, Tx_FULL=0, Tx_EMPTY=1, Tx_OVF=0.
REQ-033 While reset=0, the FSM SHALL be in IDLE, and the FIFO pointers and bit counters SHALL be cleared.
REQ-034 Reset asserted mid-frame SHALL force TxD=1 immediately (asynchronous) and discard the partial frame and all queued words.
REQ-035 Tx_OVF SHALL clear only on reset.

Configuration
REQ-036 The macro UART_TX_FIFO_EN SHALL control buffering.
REQ-037 With UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry FIFO SHALL be built as described above.
REQ-038 Without UART_TX_FIFO_EN: FIFO_DEPTH SHALL be ignored and a single holding register SHALL replace the FIFO.
REQ-039 Without UART_TX_FIFO_EN: Tx_FULL SHALL equal holding-register occupied, Tx_EMPTY SHALL be its inverse, and all other behaviour is unchanged (depth 1).

Verification
REQ-040 Defaults, baud_select=7, Tx_EN=1, write 0xA5 at edge N -> TxD=0 from edge N+2 for 14 clocks, then 1,0,1,0,0,1,0,1, parity 0, stop 1; Tx_BUSY high for 154 clocks.
REQ-041 PARITY_MODE=2, STOP_BITS=2, DATA_W=7, write 0x03 -> parity bit 1, two stop bits, frame of 154 clocks.
REQ-042 FIFO_DEPTH=8, Tx_EN=0, 9 writes -> Tx_FULL=1 after the 8th; the 9th sets Tx_OVF; after Tx_EN=1, 8 back-to-back frames with no gap and Tx_OVF still 1.
REQ-043 baud_select changed 7 -> 6 mid-frame -> current frame keeps 14-clock bits; next frame uses 27-clock bits.
REQ-044 reset pulsed low during data bit 3 with 2 words queued -> TxD=1, Tx_EMPTY=1, Tx_BUSY=0 immediately; no frame follows after release until a new write.
REQ-045 Build without UART_TX_FIFO_EN, write twice back-to-back while idle -> second write accepted once the first word is loaded; a third write during the first frame is dropped with Tx_OVF=1.

Source files
------------

// File: rtl/uart_tx_generic.sv
// UART transmitter: start/data/parity/stop framing with selectable bit period.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise one holding register.
module uart_tx_generic #(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        baud_select,
    input  logic              Tx_EN,
    input  logic              Tx_WR,
    input  logic [DATA_W-1:0] Tx_DATA,
    output logic              TxD,
    output logic              Tx_BUSY,
    output logic              Tx_FULL,
    output logic              Tx_EMPTY,
    output logic              Tx_OVF
);

    if (DATA_W < 5 || DATA_W > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx_generic: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY_MODE == 2);

    state_t            state_q, state_d;
    logic [12:0]       cyc_q, cyc_d, bitc_q;
    logic [3:0]        bitn_q, bitn_d;
    logic [DATA_W-1:0] shift_q, head;
    logic              par_q, txd_d, pop, push, bit_end;

    function automatic logic [12:0] bit_cycles(input logic [2:0] sel);
        case (sel)
            3'd0:    return 13'd5208;
            3'd1:    return 13'd1302;
            3'd2:    return 13'd326;
            3'd3:    return 13'd163;
            3'd4:    return 13'd81;
            3'd5:    return 13'd41;
            3'd6:    return 13'd27;
            default: return 13'd14;
        endcase
    endfunction

    assign push    = Tx_WR & ~Tx_FULL;
    assign bit_end = (cyc_q == bitc_q - 13'd1);
    assign Tx_BUSY = (state_q != IDLE);

`ifdef UART_TX_FIFO_EN
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       count_q, count_d;

    assign head = mem[rp_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= Tx_DATA;
    end

    // Pointers are exactly AW bits wide, so wrap modulo FIFO_DEPTH is implicit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            Tx_FULL  <= 1'b0;
            Tx_EMPTY <= 1'b1;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            count_q  <= count_d;
            Tx_FULL  <= (count_d == DEPTH_C);
            Tx_EMPTY <= (count_d == '0);
        end
    end
`else
    logic              occ_q;
    logic [DATA_W-1:0] hold_q;

    assign head     = hold_q;
    assign Tx_FULL  = occ_q;
    assign Tx_EMPTY = ~occ_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q  <= 1'b0;
            hold_q <= '0;
        end else if (push) begin
            occ_q  <= 1'b1;
            hold_q <= Tx_DATA;
        end else if (pop) begin
            occ_q  <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 13'd1;
        bitn_d  = bitn_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (!Tx_EMPTY && Tx_EN) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    cyc_d   = '0;
                    bitn_d  = '0;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (bit_end) begin
                    cyc_d = '0;
                    if (bitn_q == LAST_DATA) begin
                        bitn_d  = '0;
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bitn_d = bitn_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                txd_d = par_q;
                if (bit_end) begin
                    state_d = STOP;
                    cyc_d   = '0;
                    bitn_d  = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (bitn_q == LAST_STOP) begin
                        bitn_d = '0;
                        if (!Tx_EMPTY && Tx_EN) begin
                            state_d = START;
                            pop     = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bitn_d = bitn_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TxD is registered from the current state, so the line trails the FSM by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bitn_q  <= '0;
            bitc_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            TxD     <= 1'b1;
            Tx_OVF  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bitn_q  <= bitn_d;
            TxD     <= txd_d;
            Tx_OVF  <= Tx_OVF | (Tx_WR & Tx_FULL);
            if (pop) begin
                shift_q <= head;
                par_q   <= (^head) ^ PAR_ODD;
                bitc_q  <= bit_cycles(baud_select);
            end else if (state_q == DATA && bit_end) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_generic.sv
// Directed bench for uart_tx_generic: default instance plus a 7-bit odd-parity two-stop instance.
// Buffering checks follow UART_TX_FIFO_EN when it is defined for the build.
module tb_uart_tx_generic;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud0, baud1;
    logic       en0, en1, wr0, wr1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic       txd0, busy0, full0, empty0, ovf0;
    logic       txd1, busy1, full1, empty1, ovf1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_generic dut0 (
        .clk(clk), .reset(reset), .baud_select(baud0), .Tx_EN(en0), .Tx_WR(wr0),
        .Tx_DATA(data0), .TxD(txd0), .Tx_BUSY(busy0), .Tx_FULL(full0),
        .Tx_EMPTY(empty0), .Tx_OVF(ovf0)
    );

    uart_tx_generic #(.DATA_W(7), .PARITY_MODE(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .baud_select(baud1), .Tx_EN(en1), .Tx_WR(wr1),
        .Tx_DATA(data1), .TxD(txd1), .Tx_BUSY(busy1), .Tx_FULL(full1),
        .Tx_EMPTY(empty1), .Tx_OVF(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called #1 after an edge; writes are sampled on the following edge.
    task automatic wr_word(input int which, input logic [7:0] d);
        if (which == 0) begin wr0 = 1'b1; data0 = d; end
        else            begin wr1 = 1'b1; data1 = d[6:0]; end
        @(posedge clk); #1;
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    // Entered one sample before the start bit; checks every clock of the frame.
    task automatic expect_frame(input int which, input logic [15:0] bits, input int nbits,
                                input int bitc, input logic busy_after, input string tag);
        for (int i = 0; i < nbits * bitc; i++) begin
            @(posedge clk); #1;
            check({tag, "_txd"}, (which == 0) ? txd0 : txd1, bits[i / bitc]);
            check({tag, "_busy"}, (which == 0) ? busy0 : busy1,
                  (i < nbits * bitc - 1) || busy_after);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        baud0 = 3'd7; baud1 = 3'd7;
        en0 = 1'b1; en1 = 1'b1;
        wr0 = 1'b0; wr1 = 1'b0;
        data0 = '0; data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_full", full0, 1'b0);
        check("rst_empty", empty0, 1'b1);
        check("rst_ovf", ovf0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 0xA5 even parity: start, 1,0,1,0,0,1,0,1, parity 0, stop.
        wr_word(0, 8'hA5);
        check("a5_empty_after_wr", empty0, 1'b0);
        @(posedge clk); #1;
        check("a5_txd_still_idle", txd0, 1'b1);
        check("a5_busy_n1", busy0, 1'b1);
        expect_frame(0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 14, 1'b0, "a5");
        check("a5_empty_end", empty0, 1'b1);

        // 7-bit 0x03 odd parity: parity 1, two stop bits, 11 bits x 14 = 154 clocks.
        wr_word(1, 8'h03);
        @(posedge clk); #1;
        check("odd_txd_still_idle", txd1, 1'b1);
        expect_frame(1, {2'b11, 1'b1, 7'h03, 1'b0}, 11, 14, 1'b0, "odd03");

        // Baud change mid-frame only affects the next frame.
        wr_word(0, 8'h01);
        @(posedge clk); #1;
        fork
            begin
                expect_frame(0, {1'b1, 1'b1, 8'h01, 1'b0}, 11, 14, 1'b1, "baud7");
                expect_frame(0, {1'b1, 1'b0, 8'h96, 1'b0}, 11, 27, 1'b0, "baud6");
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                baud0 = 3'd6;
                wr_word(0, 8'h96);
            end
        join
        baud0 = 3'd7;
        repeat (3) @(posedge clk);
        #1;

`ifdef UART_TX_FIFO_EN
        en0 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wr_word(0, 8'(8'h10 + k));
            if (k == 6) check("fifo_full_after7", full0, 1'b0);
            if (k == 7) check("fifo_full_after8", full0, 1'b1);
        end
        check("fifo_ovf_after9", ovf0, 1'b1);
        check("fifo_busy_disabled", busy0, 1'b0);
        en0 = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] d;
            d = 8'(8'h10 + k);
            expect_frame(0, {1'b1, ^d, d, 1'b0}, 11, 14, k < 7, "fifo_b2b");
        end
        check("fifo_ovf_sticky", ovf0, 1'b1);
        check("fifo_empty_end", empty0, 1'b1);
`else
        wr_word(0, 8'h5A);
        check("hold_full_after_wr", full0, 1'b1);
        @(posedge clk); #1;
        check("hold_free_after_load", full0, 1'b0);
        fork
            begin
                expect_frame(0, {1'b1, 1'b0, 8'h5A, 1'b0}, 11, 14, 1'b1, "hold_a");
                expect_frame(0, {1'b1, 1'b1, 8'hC4, 1'b0}, 11, 14, 1'b0, "hold_b");
            end
            begin
                wr_word(0, 8'hC4);
                check("hold_second_accepted", full0, 1'b1);
                check("hold_ovf_clear", ovf0, 1'b0);
                wr_word(0, 8'hFF);
                check("hold_third_dropped_ovf", ovf0, 1'b1);
            end
        join
        repeat (20) @(posedge clk);
        #1;
        check("hold_no_third_frame", busy0, 1'b0);
        check("hold_ovf_sticky", ovf0, 1'b1);
`endif

        // Reset during data bit 3 of 0xA5 (bit value 0) with words queued.
        wr_word(0, 8'hA5);
        @(posedge clk); #1;
        wr_word(0, 8'h33);
`ifdef UART_TX_FIFO_EN
        wr_word(0, 8'h44);
`endif
        repeat (60) @(posedge clk);
        #1;
        check("mid_bit3_txd", txd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_txd", txd0, 1'b1);
        check("arst_busy", busy0, 1'b0);
        check("arst_empty", empty0, 1'b1);
        check("arst_full", full0, 1'b0);
        check("arst_ovf", ovf0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        begin
            int unsigned active;
            active = 0;
            repeat (200) begin
                @(posedge clk); #1;
                if (busy0 || !txd0) active++;
            end
            check("post_rst_quiet", active, 0);
        end
        wr_word(0, 8'h0F);
        @(posedge clk); #1;
        expect_frame(0, {1'b1, 1'b0, 8'h0F, 1'b0}, 11, 14, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
